// File: rtl/ppl_scheduler.sv
// ppl_scheduler: entry-slot sequencer for the ray-march loop.
//
// Each cycle it decides what occupies the pipeline entry slot: a ray that
// comes back from the pipeline exit still marching (recirculation), a new
// pixel ray from the raster scanner (next_en), or a bubble. It latches the
// camera pose once per frame, tracks issued/retired/in-flight rays and
// reports frame completion and frame duration.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   frame_start              render-one-frame request, honoured only in IDLE
//   cam_pos_x/y/z            live camera position
//   cam_angle_x/y            live camera angles (signed)
//   p_pos_x/y/z, p_angle_x/y pose latched at frame start
//   exit_valid/hit/block_cnt ray present at the pipeline exit, its hit flag
//                            and step count
//   next_en                  inject a new pixel ray (advances the scanner)
//   entry_valid              entry slot holds a live ray
//   retire_valid, retire_hit exit ray terminates; hit (1) or step limit (0)
//   frame_busy               scheduler is not IDLE
//   frame_done               one-cycle pulse after the last ray retires
//   frame_cycles             duration of the last completed frame
//   dbg_state_o              FSM state (0 IDLE, 1 ISSUE, 2 DRAIN)
//   dbg_issued_o             rays issued so far this frame
//   dbg_inflight_o           rays currently inside the loop
//
// Handshake: there is no back-pressure. exit_valid qualifies exit_hit and
// exit_block_cnt for exactly the cycle it is high; next_en and entry_valid
// are single-cycle strobes that the entry stage must accept unconditionally.
module ppl_scheduler #(
  parameter int H_DISP       = 1280,
  parameter int V_DISP       = 720,
  parameter int MAX_STEPS    = 32,
  parameter int MAX_INFLIGHT = 64,
  localparam int INFL_W = ($clog2(MAX_INFLIGHT + 1) > 7) ? $clog2(MAX_INFLIGHT + 1) : 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic [15:0]       cam_pos_x,
  input  logic [15:0]       cam_pos_y,
  input  logic [15:0]       cam_pos_z,
  input  logic signed [15:0] cam_angle_x,
  input  logic signed [15:0] cam_angle_y,
  output logic [15:0]       p_pos_x,
  output logic [15:0]       p_pos_y,
  output logic [15:0]       p_pos_z,
  output logic signed [15:0] p_angle_x,
  output logic signed [15:0] p_angle_y,
  input  logic              exit_valid,
  input  logic              exit_hit,
  input  logic [5:0]        exit_block_cnt,
  output logic              next_en,
  output logic              entry_valid,
  output logic              retire_valid,
  output logic              retire_hit,
  output logic              frame_busy,
  output logic              frame_done,
  output logic [31:0]       frame_cycles,
  output logic [1:0]        dbg_state_o,
  output logic [19:0]       dbg_issued_o,
  output logic [INFL_W-1:0] dbg_inflight_o
);

  localparam int CNT_W = 20;
  localparam logic [CNT_W-1:0]  TOTAL_C     = CNT_W'(H_DISP * V_DISP);
  localparam logic [6:0]        MAX_STEPS_C = 7'(MAX_STEPS);
  localparam logic [INFL_W-1:0] MAX_INFL_C  = INFL_W'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [INFL_W-1:0] inflight_q, inflight_d;
  logic [31:0]       cyc_q, cyc_d;
  logic [31:0]       frame_cycles_q, frame_cycles_d;
  logic              frame_done_q, frame_done_d;
  logic [15:0]       pos_x_q, pos_x_d, pos_y_q, pos_y_d, pos_z_q, pos_z_d;
  logic [15:0]       ang_x_q, ang_x_d, ang_y_q, ang_y_d;

  logic active;
  logic term;
  logic recirc;
  logic issue;
  logic credit_ok;

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      issued_q       <= '0;
      retired_q      <= '0;
      inflight_q     <= '0;
      cyc_q          <= '0;
      frame_cycles_q <= '0;
      frame_done_q   <= 1'b0;
      pos_x_q        <= '0;
      pos_y_q        <= '0;
      pos_z_q        <= '0;
      ang_x_q        <= '0;
      ang_y_q        <= '0;
    end else begin
      state_q        <= state_d;
      issued_q       <= issued_d;
      retired_q      <= retired_d;
      inflight_q     <= inflight_d;
      cyc_q          <= cyc_d;
      frame_cycles_q <= frame_cycles_d;
      frame_done_q   <= frame_done_d;
      pos_x_q        <= pos_x_d;
      pos_y_q        <= pos_y_d;
      pos_z_q        <= pos_z_d;
      ang_x_q        <= ang_x_d;
      ang_y_q        <= ang_y_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    issued_d       = issued_q + CNT_W'(issue);
    retired_d      = retired_q + CNT_W'(term);
    inflight_d     = inflight_q + INFL_W'(issue) - INFL_W'(term);
    cyc_d          = active ? (cyc_q + 32'd1) : cyc_q;
    frame_cycles_d = frame_cycles_q;
    frame_done_d   = 1'b0;
    pos_x_d        = pos_x_q;
    pos_y_d        = pos_y_q;
    pos_z_d        = pos_z_q;
    ang_x_d        = ang_x_q;
    ang_y_d        = ang_y_q;

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d    = S_ISSUE;
          issued_d   = '0;
          retired_d  = '0;
          inflight_d = '0;
          cyc_d      = '0;
          pos_x_d    = cam_pos_x;
          pos_y_d    = cam_pos_y;
          pos_z_d    = cam_pos_z;
          ang_x_d    = cam_angle_x;
          ang_y_d    = cam_angle_y;
        end
      end
      S_ISSUE: begin
        // Final-retire check comes first so a frame can never get stuck in
        // DRAIN waiting for a retire that already happened.
        if (term && retired_d == TOTAL_C) begin
          state_d = S_IDLE;
        end else if (issued_d == TOTAL_C) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (term && retired_d == TOTAL_C) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The frame window runs from the first ISSUE cycle through the cycle of
    // the final retire inclusive, hence cyc_q + 1.
    if (active && term && retired_d == TOTAL_C) begin
      frame_done_d   = 1'b1;
      frame_cycles_d = cyc_q + 32'd1;
    end
  end

  // ---------------------------------------------------------------------
  // Output / entry-slot logic
  // ---------------------------------------------------------------------
  always_comb begin
    active    = (state_q != S_IDLE);
    term      = active & exit_valid & (exit_hit | ({1'b0, exit_block_cnt} >= MAX_STEPS_C));
    recirc    = active & exit_valid & ~term;
    // A ray terminating this cycle frees its credit immediately, so a full
    // loop can still take a new ray in the same cycle without overflowing.
    credit_ok = (inflight_q < MAX_INFL_C) | term;
    issue     = ~recirc & (state_q == S_ISSUE) & (issued_q < TOTAL_C) & credit_ok;

    next_en        = issue;
    entry_valid    = recirc | issue;
    retire_valid   = term;
    retire_hit     = exit_hit & term;
    frame_busy     = active;
    frame_done     = frame_done_q;
    frame_cycles   = frame_cycles_q;
    p_pos_x        = pos_x_q;
    p_pos_y        = pos_y_q;
    p_pos_z        = pos_z_q;
    p_angle_x      = ang_x_q;
    p_angle_y      = ang_y_q;
    dbg_state_o    = state_q;
    dbg_issued_o   = issued_q;
    dbg_inflight_o = inflight_q;
  end

  // ---------------------------------------------------------------------
  // Protocol checks
  // ---------------------------------------------------------------------
  a_inflight_max: assert property (@(posedge clk) disable iff (rst)
    inflight_q <= MAX_INFL_C);

  a_inflight_min: assert property (@(posedge clk) disable iff (rst)
    !(term && !issue && inflight_q == '0));

  a_exit_in_idle: assert property (@(posedge clk) disable iff (rst)
    !(exit_valid && state_q == S_IDLE));

endmodule

// File: tb/tb_ppl_scheduler.sv
// Testbench for ppl_scheduler with a 4x2 frame, MAX_STEPS=4, MAX_INFLIGHT=3.
// A table of per-cycle vectors walks one frame through recirculation,
// step-limit, credit-stall and drain cases; hand-written sequences then run
// a 2-cycle-latency model pipeline for pose/busy checks and a mid-frame reset.
module tb_ppl_scheduler;

  localparam int TOTAL = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              frame_start = 1'b0;
  logic [15:0]       cam_pos_x = '0, cam_pos_y = '0, cam_pos_z = '0;
  logic signed [15:0] cam_angle_x = '0, cam_angle_y = '0;
  logic [15:0]       p_pos_x, p_pos_y, p_pos_z;
  logic signed [15:0] p_angle_x, p_angle_y;
  logic              exit_valid = 1'b0;
  logic              exit_hit = 1'b0;
  logic [5:0]        exit_block_cnt = '0;
  logic              next_en, entry_valid, retire_valid, retire_hit;
  logic              frame_busy, frame_done;
  logic [31:0]       frame_cycles;
  logic [1:0]        dbg_state_o;
  logic [19:0]       dbg_issued_o;
  logic [6:0]        dbg_inflight_o;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  ppl_scheduler #(
    .H_DISP(4), .V_DISP(2), .MAX_STEPS(4), .MAX_INFLIGHT(3)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .cam_pos_x(cam_pos_x), .cam_pos_y(cam_pos_y), .cam_pos_z(cam_pos_z),
    .cam_angle_x(cam_angle_x), .cam_angle_y(cam_angle_y),
    .p_pos_x(p_pos_x), .p_pos_y(p_pos_y), .p_pos_z(p_pos_z),
    .p_angle_x(p_angle_x), .p_angle_y(p_angle_y),
    .exit_valid(exit_valid), .exit_hit(exit_hit), .exit_block_cnt(exit_block_cnt),
    .next_en(next_en), .entry_valid(entry_valid),
    .retire_valid(retire_valid), .retire_hit(retire_hit),
    .frame_busy(frame_busy), .frame_done(frame_done), .frame_cycles(frame_cycles),
    .dbg_state_o(dbg_state_o), .dbg_issued_o(dbg_issued_o), .dbg_inflight_o(dbg_inflight_o)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [0:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       fs;
    logic       ev;
    logic       eh;
    logic [5:0] bc;
    logic [5:0] exp_o;     // {next_en, entry_valid, retire_valid, retire_hit, frame_busy, frame_done}
    logic [6:0] exp_infl;  // in-flight count before the clock edge
    logic [19:0] exp_iss;  // issued count before the clock edge
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic fs, input logic ev, input logic eh, input logic [5:0] bc,
                         input logic [5:0] eo, input logic [6:0] ei, input logic [19:0] es);
    vec_t v;
    v.fs = fs; v.ev = ev; v.eh = eh; v.bc = bc;
    v.exp_o = eo; v.exp_infl = ei; v.exp_iss = es;
    vecs.push_back(v);
  endtask

  // ---------------- model pipeline driver ----------------
  logic pipe0 = 1'b0;
  logic pipe1 = 1'b0;
  int   n_issue, n_hit, n_done, max_infl, busy_err, busy_cyc;
  logic timed_out;

  // Runs a frame against a 2-cycle-latency pipeline that hits on every ray.
  // Stops after frame_done, or right after the stop_issues-th next_en when
  // stop_issues < TOTAL. With poke set, the camera angle changes and a
  // frame_start is raised mid-frame.
  task automatic run_auto(input int stop_issues, input logic poke);
    logic ent;
    logic finished;
    n_issue = 0; n_hit = 0; n_done = 0; max_infl = 0; busy_err = 0; busy_cyc = 0;
    finished = 1'b0;
    @(negedge clk);
    frame_start = 1'b1; exit_valid = 1'b0; exit_hit = 1'b0; exit_block_cnt = '0;
    @(posedge clk);
    for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
      @(negedge clk);
      frame_start = 1'b0;
      if (poke && n_issue == 3) begin
        cam_angle_x = 16'sd300;
        frame_start = 1'b1;
      end
      exit_valid = pipe1; exit_hit = 1'b1; exit_block_cnt = 6'd0;
      #1;
      if (frame_done) begin
        n_done++;
        finished = 1'b1;
      end else begin
        if (frame_busy) busy_cyc++; else busy_err++;
        if (int'(dbg_inflight_o) > max_infl) max_infl = int'(dbg_inflight_o);
        if (retire_valid) begin
          if (exp_q.size() == 0) chk("retire_without_ray", 64'(retire_valid), 64'd0);
          else chk("retire_kind", 64'(retire_hit), 64'(exp_q.pop_front()));
          if (retire_hit) n_hit++;
        end
        if (next_en) begin
          n_issue++;
          exp_q.push_back(1'b1);
        end
        if (stop_issues < TOTAL && n_issue == stop_issues) begin
          finished = 1'b1;
        end else begin
          ent = entry_valid;
          @(posedge clk);
          pipe1 = pipe0;
          pipe0 = ent;
        end
      end
    end
    timed_out = !finished;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    frame_start = 1'b0; exit_valid = 1'b0; exit_hit = 1'b0; exit_block_cnt = '0;
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_outputs", 64'({next_en, entry_valid, retire_valid, retire_hit, frame_busy, frame_done}), 64'd0);
    chk("rst_frame_cycles", 64'(frame_cycles), 64'd0);
    chk("rst_state", 64'(dbg_state_o), 64'd0);
    chk("rst_inflight", 64'(dbg_inflight_o), 64'd0);
    rst = 1'b0;

    // Directed single frame, one row per cycle.
    //       fs    ev    eh    bc     {ne,ev,rv,rh,busy,done}  infl  issued
    add_vec(1'b1, 1'b0, 1'b0, 6'd0, 6'b000000, 7'd0, 20'd0);  // start in IDLE
    add_vec(1'b0, 1'b0, 1'b0, 6'd0, 6'b110010, 7'd0, 20'd0);  // first issue
    add_vec(1'b0, 1'b0, 1'b0, 6'd0, 6'b110010, 7'd1, 20'd1);
    add_vec(1'b0, 1'b1, 1'b0, 6'd1, 6'b010010, 7'd2, 20'd2);  // recirc beats new ray
    add_vec(1'b0, 1'b0, 1'b0, 6'd0, 6'b110010, 7'd2, 20'd2);
    add_vec(1'b0, 1'b0, 1'b0, 6'd0, 6'b000010, 7'd3, 20'd3);  // credit stall
    add_vec(1'b1, 1'b0, 1'b0, 6'd0, 6'b000010, 7'd3, 20'd3);  // frame_start ignored
    add_vec(1'b0, 1'b1, 1'b0, 6'd4, 6'b111010, 7'd3, 20'd3);  // step limit + issue at full
    add_vec(1'b0, 1'b1, 1'b1, 6'd2, 6'b111110, 7'd3, 20'd4);  // hit + issue
    add_vec(1'b0, 1'b1, 1'b0, 6'd3, 6'b010010, 7'd3, 20'd5);  // cnt 3 recirculates
    add_vec(1'b0, 1'b1, 1'b0, 6'd0, 6'b010010, 7'd3, 20'd5);  // cnt 0 recirculates
    add_vec(1'b0, 1'b0, 1'b0, 6'd0, 6'b000010, 7'd3, 20'd5);
    add_vec(1'b0, 1'b1, 1'b1, 6'd0, 6'b111110, 7'd3, 20'd5);
    add_vec(1'b0, 1'b1, 1'b1, 6'd0, 6'b111110, 7'd3, 20'd6);
    add_vec(1'b0, 1'b1, 1'b1, 6'd0, 6'b111110, 7'd3, 20'd7);  // last issue
    add_vec(1'b0, 1'b1, 1'b0, 6'd1, 6'b010010, 7'd3, 20'd8);  // DRAIN recirc
    add_vec(1'b0, 1'b1, 1'b0, 6'd2, 6'b010010, 7'd3, 20'd8);  // cnt 2 recirculates
    add_vec(1'b0, 1'b1, 1'b1, 6'd0, 6'b001110, 7'd3, 20'd8);
    add_vec(1'b0, 1'b1, 1'b0, 6'd5, 6'b001010, 7'd2, 20'd8);  // above limit
    add_vec(1'b0, 1'b1, 1'b1, 6'd0, 6'b001110, 7'd1, 20'd8);  // final retire
    add_vec(1'b0, 1'b0, 1'b0, 6'd0, 6'b000001, 7'd0, 20'd8);  // frame_done
    add_vec(1'b0, 1'b0, 1'b0, 6'd0, 6'b000000, 7'd0, 20'd8);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      frame_start = vecs[i].fs; exit_valid = vecs[i].ev;
      exit_hit = vecs[i].eh; exit_block_cnt = vecs[i].bc;
      #1;
      chk($sformatf("vec%0d_out", i),
          64'({next_en, entry_valid, retire_valid, retire_hit, frame_busy, frame_done}),
          64'(vecs[i].exp_o));
      chk($sformatf("vec%0d_inflight", i), 64'(dbg_inflight_o), 64'(vecs[i].exp_infl));
      chk($sformatf("vec%0d_issued", i), 64'(dbg_issued_o), 64'(vecs[i].exp_iss));
    end
    idle_cycle();
    chk("table_frame_cycles", 64'(frame_cycles), 64'd19);

    // Single-pass frame with pose latch, mid-frame camera change and an
    // ignored frame_start.
    cam_pos_x = 16'h1234; cam_pos_y = 16'h0042; cam_pos_z = 16'hbeef;
    cam_angle_x = 16'sd100; cam_angle_y = -16'sd50;
    run_auto(TOTAL, 1'b1);
    chk("auto_timeout", 64'(timed_out), 64'd0);
    chk("auto_issues", 64'(n_issue), 64'd8);
    chk("auto_hits", 64'(n_hit), 64'd8);
    chk("auto_done", 64'(n_done), 64'd1);
    chk("auto_max_inflight_le3", 64'(max_infl <= 3), 64'd1);
    chk("auto_busy_gaps", 64'(busy_err), 64'd0);
    chk("auto_busy_cycles", 64'(busy_cyc), 64'd10);
    chk("auto_frame_cycles", 64'(frame_cycles), 64'(busy_cyc));
    chk("auto_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("pose_xyz", 64'({p_pos_x, p_pos_y, p_pos_z}), 64'h0000_1234_0042_beef);
    chk("pose_angle_x", {48'd0, p_angle_x}, 64'd100);
    chk("pose_angle_y", {48'd0, p_angle_y}, 64'h0000_0000_0000_ffce);
    repeat (3) idle_cycle();
    chk("pose_hold_idle", {48'd0, p_angle_x}, 64'd100);

    // Reset after 5 issues, then a fresh frame.
    run_auto(5, 1'b0);
    chk("rstmid_issues", 64'(n_issue), 64'd5);
    chk("rstmid_new_pose", {48'd0, p_angle_x}, 64'd300);
    rst = 1'b1; exit_valid = 1'b0; pipe0 = 1'b0; pipe1 = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid_outputs", 64'({next_en, entry_valid, retire_valid, retire_hit, frame_busy, frame_done}), 64'd0);
    chk("rstmid_state", 64'(dbg_state_o), 64'd0);
    chk("rstmid_frame_cycles", 64'(frame_cycles), 64'd0);
    chk("rstmid_pose_xyz", 64'({p_pos_x, p_pos_y, p_pos_z}), 64'd0);
    chk("rstmid_pose_ang", 64'({p_angle_x, p_angle_y}), 64'd0);
    for (int i = 0; i < 4; i++) begin
      idle_cycle();
      chk("rstmid_no_done", 64'(frame_done), 64'd0);
    end
    run_auto(TOTAL, 1'b0);
    chk("refr_timeout", 64'(timed_out), 64'd0);
    chk("refr_issues", 64'(n_issue), 64'd8);
    chk("refr_done", 64'(n_done), 64'd1);
    chk("refr_frame_cycles", 64'(frame_cycles), 64'd10);
    chk("refr_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
